// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: redirect encodings,
// reset PC default, instruction width and a branch-offset helper.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int          INSTR_W      = 32;

    typedef enum logic [1:0] {
        REDIR_BR  = 2'b00,
        REDIR_J   = 2'b01,
        REDIR_JR  = 2'b10,
        REDIR_RSV = 2'b11
    } redir_sel_e;

    // Sign-extend a 16-bit branch offset and scale it to a byte offset.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// Next-PC computation: the sequential PC, or a branch / jump / jump-register
// target for the instruction currently held in IF/ID. Purely combinational.
module ifu_npc
    import ifu_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] id_pc,
    input  logic [1:0]  redir_sel,
    input  logic [15:0] imm16,
    input  logic [25:0] jidx26,
    input  logic [31:0] jr_target,
    output logic [31:0] npc,
    output logic        align_fault
);

    logic [31:0] id_pc_plus4_s;
    logic [31:0] npc_s;
    logic        align_fault_s;

    assign id_pc_plus4_s = id_pc + 32'd4;

    // Select the next fetch address for the requested transfer kind.
    always_comb begin
        npc_s         = pc + 32'd4;
        align_fault_s = 1'b0;
        case (redir_sel)
            REDIR_BR: begin
                npc_s = id_pc_plus4_s + br_offset(imm16);
            end
            REDIR_J: begin
                npc_s = {id_pc_plus4_s[31:28], jidx26, 2'b00};
            end
            REDIR_JR: begin
                npc_s = {jr_target[31:2], 2'b00};
                if (jr_target[1:0] != 2'b00) begin
                    align_fault_s = 1'b1;
                end else begin
                    align_fault_s = 1'b0;
                end
            end
            default: begin
                // Reserved encoding behaves as no redirect.
                npc_s         = pc + 32'd4;
                align_fault_s = 1'b0;
            end
        endcase
    end

    assign npc         = npc_s;
    assign align_fault = align_fault_s;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, instruction-memory addressing,
// IF/ID pipeline register and sticky jump-register alignment flag.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IM_AW    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redir,
    input  logic [1:0]           redir_sel,
    input  logic [15:0]          imm16,
    input  logic [25:0]          jidx26,
    input  logic [31:0]          jr_target,
    output logic [IM_AW-1:0]     im_addr,
    input  logic [INSTR_W-1:0]   im_dout,
    output logic [31:0]          pc,
    output logic                 id_valid,
    output logic [INSTR_W-1:0]   id_instr,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_pc_plus4,
    output logic                 align_err
);

    logic [31:0]        pc_r;
    logic               id_valid_r;
    logic [INSTR_W-1:0] id_instr_r;
    logic [31:0]        id_pc_r;
    logic [31:0]        id_pc_plus4_r;
    logic               align_err_r;

    logic [31:0]        npc_s;
    logic               align_fault_s;
    logic               redir_take_s;

    ifu_npc u_npc (
        .pc          (pc_r),
        .id_pc       (id_pc_r),
        .redir_sel   (redir_sel),
        .imm16       (imm16),
        .jidx26      (jidx26),
        .jr_target   (jr_target),
        .npc         (npc_s),
        .align_fault (align_fault_s)
    );

    // A redirect only applies to a live IF/ID instruction with a defined kind.
    always_comb begin
        redir_take_s = 1'b0;
        if (redir && id_valid_r && (redir_sel != REDIR_RSV)) begin
            redir_take_s = 1'b1;
        end else begin
            redir_take_s = 1'b0;
        end
    end

    // PC and IF/ID update: reset beats stall, stall beats redirect,
    // redirect squashes the wrong-path fetch, otherwise fetch sequentially.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            id_valid_r    <= 1'b0;
            id_instr_r    <= {INSTR_W{1'b0}};
            id_pc_r       <= 32'd0;
            id_pc_plus4_r <= 32'd4;
            align_err_r   <= 1'b0;
        end else if (stall) begin
            pc_r          <= pc_r;
            id_valid_r    <= id_valid_r;
        end else if (redir_take_s) begin
            pc_r          <= npc_s;
            id_valid_r    <= 1'b0;
            if (align_fault_s) begin
                align_err_r <= 1'b1;
            end
        end else begin
            pc_r          <= pc_r + 32'd4;
            id_valid_r    <= 1'b1;
            id_instr_r    <= im_dout;
            id_pc_r       <= pc_r;
            id_pc_plus4_r <= pc_r + 32'd4;
        end
    end

    // Memory index wraps with the memory size; upper PC bits are ignored.
    assign im_addr     = pc_r[IM_AW+1:2];
    assign pc          = pc_r;
    assign id_valid    = id_valid_r;
    assign id_instr    = id_instr_r;
    assign id_pc       = id_pc_r;
    assign id_pc_plus4 = id_pc_plus4_r;
    assign align_err   = align_err_r;

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the single-issue MIPS core: holds the program counter, drives the word address into the 4 KiB instruction memory, captures the returned word into an IF/ID register, and computes the next PC (sequential, branch, jump, jump-register). It is the initiator on the instruction-memory read interface. Decode feeds it stall and redirect requests for the instruction held in IF/ID.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- IM_AW, 10, instruction-memory word-address width (address bits [IM_AW+1:2])
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  decode hazard; hold PC and IF/ID
- redir  in  1  decode requests a control transfer for the instruction in IF/ID
- redir_sel  in  2  00 branch, 01 jump (j/jal), 10 jump-register, 11 reserved (treated as no redirect)
- imm16  in  16  branch offset field of IF/ID instruction
- jidx26  in  26  jump index field of IF/ID instruction
- jr_target  in  32  register value for jr/jalr
- im_addr  out  IM_AW  word address to instruction memory (pc[IM_AW+1:2])
- im_dout  in  32  instruction word from memory, combinational on im_addr
- pc  out  32  current fetch PC
- id_valid  out  1  IF/ID holds a live instruction
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  PC of id_instr
- id_pc_plus4  out  32  id_pc + 4 (link value for jal/jalr)
- align_err  out  1  sticky: a jump-register target had nonzero bits [1:0]

## Operation
- No branch delay slot; redirect squashes the wrong-path fetch.
- Target computation, all 32-bit, wrap on overflow:
  - branch: id_pc + 4 + (sign_extend(imm16) << 2)
  - jump: {id_pc_plus4[31:28], jidx26, 2'b00}
  - jump-register: {jr_target[31:2], 2'b00}; if jr_target[1:0] != 0, set align_err
- Per-cycle priority (rst > stall > redir > sequential):
  - rst: pc <= RESET_PC; id_valid <= 0; id_instr <= 0; id_pc <= 0; align_err <= 0
  - stall: pc, id_* registers hold; redir ignored this cycle (decode re-asserts it)
  - redir (valid sel, id_valid=1): pc <= target; id_valid <= 0 (squash)
  - redir with id_valid=0: ignored, treated as sequential
  - sequential: pc <= pc + 4; id_instr <= im_dout; id_pc <= pc; id_valid <= 1
- im_addr wraps modulo the memory size (pc bits above IM_AW+1 are not used for addressing); RESET_PC 0x3000 maps to word 0.
- pc[1:0] is always 00.

## Timing
- Fetch-to-IF/ID latency: 1 cycle (im_dout sampled on edge ending the cycle pc is presented).
- First valid instruction: id_valid=1 on the first edge after rst deasserts, id_pc=RESET_PC.
- Redirect penalty: 1 bubble (id_valid=0 for one cycle), then target instruction in IF/ID on the following edge.
- Stall of N cycles: IF/ID unchanged for N cycles, no fetch lost or duplicated.
- rst asserted mid-redirect or mid-stall: reset wins in that cycle, outputs reach reset values on that edge.
- align_err clears only on rst.

## Structure
- Shared package: redir_sel encodings (REDIR_BR, REDIR_J, REDIR_JR), RESET_PC default, instruction width.
- One natural sub-module: ifu_npc (combinational next-PC mux/adder: inputs pc, id_pc, redir_sel, imm16, jidx26, jr_target; outputs npc, align_fault). PC and IF/ID registers remain in ifu_fetch.

## Test plan
- Reset then 4 free-running cycles, memory preloaded words 0..3 = 0x11,0x22,0x33,0x44 -> id_pc 0x3000,0x3004,0x3008,0x300C with matching id_instr, id_valid=1 from first edge.
- Branch at id_pc 0x3004, imm16=0xFFFF -> next pc 0x3004, one cycle id_valid=0, then id_pc=0x3004.
- Jump at id_pc 0x3008, jidx26=0x0000C10 -> pc 0x00003040, one bubble, id_instr = word 16.
- jr with jr_target=0x0000_3022 -> pc 0x3020, align_err=1 and held until rst.
- stall high 3 cycles with redir asserted concurrently -> pc and IF/ID frozen, redirect not taken; redir after stall drop -> taken.
- rst asserted in the same cycle as redir -> pc=0x3000, id_valid=0, align_err=0.
